// File: rtl/riscv_constants.sv
// Shared RV32I decode constants: operand-2 select codes, opcodes and the
// registered decode bundle carried through the decode stage.
package riscv_constants;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OP2_RS2 = 3'd0,
    OP2_IMI = 3'd1,
    OP2_IMS = 3'd2,
    OP2_IMJ = 3'd3,
    OP2_IMU = 3'd4,
    OP2_X   = 3'd5
  } op2_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    op2_sel_e        op2_sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic            illegal;
  } decode_bundle_t;

  localparam decode_bundle_t BUNDLE_RESET = '{
    pc:      '0,
    op2_sel: OP2_X,
    rs1:     '0,
    rs2:     '0,
    rd:      '0,
    imm_i:   '0,
    imm_s:   '0,
    imm_j:   '0,
    imm_u:   '0,
    illegal: 1'b0
  };

  function automatic op2_sel_e op2_sel_of(input logic [6:0] opcode);
    op2_sel_e sel;
    case (opcode)
      OPC_OP, OPC_BRANCH:             sel = OP2_RS2;
      OPC_OPIMM, OPC_LOAD, OPC_JALR:  sel = OP2_IMI;
      OPC_STORE:                      sel = OP2_IMS;
      OPC_JAL:                        sel = OP2_IMJ;
      OPC_LUI, OPC_AUIPC:             sel = OP2_IMU;
      default:                        sel = OP2_X;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate extraction; every format is produced for
// every instruction, the consumer picks via the operand-2 select.
module riscv_imm_gen
  import riscv_constants::*;
(
  input  logic [31:7]     inst_i,
  output logic [XLEN-1:0] imm_i_o,
  output logic [XLEN-1:0] imm_s_o,
  output logic [XLEN-1:0] imm_j_o,
  output logic [XLEN-1:0] imm_u_o
);

  assign imm_i_o = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_j_o = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u_o = {inst_i[31:12], 12'b0};

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: operand-2 class and immediates, registered behind a
// 2-entry skid buffer so in_ready is a flop and throughput is one per cycle.
module riscv_decode_stage
  import riscv_constants::*;
#(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_inst,
  input  logic [WORD_LENGTH-1:0] in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_pc,
  output op2_sel_e               out_op2_sel,
  output logic [4:0]             out_rs1_addr,
  output logic [4:0]             out_rs2_addr,
  output logic [4:0]             out_rd_addr,
  output logic [WORD_LENGTH-1:0] out_imm_i_sext,
  output logic [WORD_LENGTH-1:0] out_imm_s_sext,
  output logic [WORD_LENGTH-1:0] out_imm_j_sext,
  output logic [WORD_LENGTH-1:0] out_imm_u_sext,
  output logic                   out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  decode_bundle_t main_q, main_d;
  decode_bundle_t skid_q, skid_d;
  decode_bundle_t dec;
  logic           in_ready_q;
  logic           accept, retire;
  logic [XLEN-1:0] imm_i, imm_s, imm_j, imm_u;

  riscv_imm_gen u_imm_gen (
    .inst_i  (in_inst[31:7]),
    .imm_i_o (imm_i),
    .imm_s_o (imm_s),
    .imm_j_o (imm_j),
    .imm_u_o (imm_u)
  );

  always_comb begin
    dec         = BUNDLE_RESET;
    dec.pc      = in_pc;
    dec.op2_sel = op2_sel_of(in_inst[6:0]);
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.rd      = in_inst[11:7];
    dec.imm_i   = imm_i;
    dec.imm_s   = imm_s;
    dec.imm_j   = imm_j;
    dec.imm_u   = imm_u;
    dec.illegal = (dec.op2_sel == OP2_X);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign retire    = out_valid && out_ready;

  // Flush wins over everything; a coincident retire has already been seen
  // by execute, so dropping the entry here completes it.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && !retire) begin
            skid_d  = dec;
            state_d = FULL;
          end else if (accept && retire) begin
            main_d  = dec;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (retire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= BUNDLE_RESET;
      skid_q     <= BUNDLE_RESET;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign out_pc         = main_q.pc;
  assign out_op2_sel    = main_q.op2_sel;
  assign out_rs1_addr   = main_q.rs1;
  assign out_rs2_addr   = main_q.rs2;
  assign out_rd_addr    = main_q.rd;
  assign out_imm_i_sext = main_q.imm_i;
  assign out_imm_s_sext = main_q.imm_s;
  assign out_imm_j_sext = main_q.imm_j;
  assign out_imm_u_sext = main_q.imm_u;
  assign out_illegal    = main_q.illegal;

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Decode pipeline stage that produces the operand-2 select code and all sign-extended immediates consumed by the execute-stage operand-2 multiplexer.
- Accepts a fetched instruction and PC over a valid/ready handshake, decodes RV32I operand-2 class and immediates, and registers the results.
- Contains a 2-entry skid buffer, so in_ready is registered and the stage sustains full throughput under back-pressure.
- Sits between fetch and execute.

Parameters:
WORD_LENGTH, 32, datapath width of instruction, PC and immediates (only 32 supported).

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  discard all buffered and in-flight instructions (branch redirect)
in_valid  input  1  fetch offers inst/pc
in_ready  output  1  stage can accept; registered, depends only on buffer state
in_inst  input  WORD_LENGTH  instruction word
in_pc  input  WORD_LENGTH  instruction address
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute consumes bundle
out_pc  output  WORD_LENGTH  PC of bundle
out_op2_sel  output  OP2_SEL  operand-2 select
out_rs1_addr, out_rs2_addr, out_rd_addr  output  5 each  register indices inst[19:15], [24:20], [11:7]
out_imm_i_sext, out_imm_s_sext, out_imm_j_sext, out_imm_u_sext  output  WORD_LENGTH each  immediates
out_illegal  output  1  opcode not recognised

Behaviour:
- Reset (rst=1 at edge): state EMPTY, out_valid=0, in_ready=1 the following cycle, all data outputs 0, out_op2_sel=OP2_X, out_illegal=0. Mid-operation reset drops all contents.
- Transfers: accept when in_valid&&in_ready; retire when out_valid&&out_ready. in_valid and in_inst need not be stable while in_ready=0.
- Buffer: main register drives outputs; skid register holds one overflow entry.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid, in_ready=1.
  - FULL: main and skid valid, in_ready=0.
- Transitions:
  - EMPTY+accept -> ONE.
  - ONE+accept, no retire -> FULL, new entry into skid.
  - ONE+accept+retire -> ONE, new entry into main.
  - ONE+retire only -> EMPTY.
  - FULL+retire -> ONE, skid moves to main.
- Latency: bundle valid on outputs the cycle after acceptance. Order is strictly preserved.
- Flush: highest priority. State goes to EMPTY and out_valid=0 next cycle. An accept coincident with flush is discarded. A retire coincident with flush is still a completed transfer.
- Decode is combinational on in_inst. It is registered on accept.
- Opcode to op2_sel mapping, by in_inst[6:0]:
  - 0110011 (OP) and 1100011 (BRANCH): OP2_RS2.
  - 0010011, 0000011, 1100111: OP2_IMI.
  - 0100011: OP2_IMS.
  - 1101111: OP2_IMJ.
  - 0110111, 0010111: OP2_IMU.
  - Any other opcode: OP2_X and out_illegal=1.
- Immediates are always computed regardless of opcode:
  - I = sext(inst[31:20]).
  - S = sext({inst[31:25],inst[11:7]}).
  - J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - U = {inst[31:12],12'b0}.
- Simultaneous accept and retire in FULL cannot occur, because in_ready=0 in FULL.

Decomposition:
- Shared constants package (riscv_constants) holds:
  - OP2_SEL enum (OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU, OP2_X);
  - opcode localparams;
  - a packed decode-bundle struct (pc, op2_sel, register indices, immediates, illegal).
- Sub-module riscv_imm_gen: pure combinational immediate extraction. The stage instantiates it once and reuses the bundle struct for both main and skid registers.

Test Plan:
1. 0xFFB10093 (addi x1,x2,-5) with out_ready=1 -> next cycle out_valid=1, op2_sel=OP2_IMI, imm_i=0xFFFFFFFB, rd=1, rs1=2, illegal=0.
2. 0x00512423 (sw x5,8(x2)), 0x123451B7 (lui x3,0x12345), 0xFFDFF0EF (jal x1,-4), back-to-back:
   - sw -> OP2_IMS, imm_s=0x00000008.
   - lui -> OP2_IMU, imm_u=0x12345000.
   - jal -> OP2_IMJ, imm_j=0xFFFFFFFC.
   - One bundle per cycle, no bubbles.
3. out_ready=0 for 4 cycles, in_valid=1 streaming PCs 0x0,0x4,0x8 -> exactly 2 accepted, in_ready=0 from the cycle after the 2nd accept. On release, PCs 0x0 then 0x4 emerge in order, then 0x8 is accepted.
4. flush asserted while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, state EMPTY. Neither buffered entry nor the offered instruction ever appears.
5. 0x00000000 -> out_illegal=1, op2_sel=OP2_X. 0x002081B3 (add) -> OP2_RS2, rs2=2.
6. rst asserted while FULL -> next cycle out_valid=0, all data outputs 0, in_ready=1.
